// File: rtl/note_recorder.sv
// Records player key presses into red/yellow/blue lanes, one slot per beat tick.
// Optional: define NOTE_RECORDER_SINGLE_LANE_EN to commit at most one lane per slot.
module note_recorder #(
  parameter int LANE_LEN = 100,
  parameter int IDX_W    = 7
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                beat_tick,
  input  logic                start,
  input  logic                stop,
  input  logic [2:0]          keys_n,
  output logic [LANE_LEN-1:0] rec_red,
  output logic [LANE_LEN-1:0] rec_yellow,
  output logic [LANE_LEN-1:0] rec_blue,
  output logic [7:0]          total_notes,
  output logic [IDX_W-1:0]    beat_idx,
  output logic                recording,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, RECORD, DONE} state_t;
  state_t state;

  logic [2:0] sync1, sync2, prev, pending;
  logic [2:0] press, slot_raw, slot;
  logic [1:0] slot_cnt;
  logic [8:0] sum;
  logic       last_slot;

  // keys_n is active-low, so a press is a 1->0 edge after the synchronizer
  always_comb begin
    press    = prev & ~sync2;
    slot_raw = pending | press;
`ifdef NOTE_RECORDER_SINGLE_LANE_EN
    if (slot_raw[2])      slot = 3'b100;
    else if (slot_raw[1]) slot = 3'b010;
    else if (slot_raw[0]) slot = 3'b001;
    else                  slot = 3'b000;
`else
    slot = slot_raw;
`endif
    slot_cnt  = {1'b0, slot[2]} + {1'b0, slot[1]} + {1'b0, slot[0]};
    sum       = {1'b0, total_notes} + {7'b0, slot_cnt};
    last_slot = (int'(beat_idx) == LANE_LEN - 1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      sync1       <= 3'b111;
      sync2       <= 3'b111;
      prev        <= 3'b111;
      pending     <= 3'b000;
      rec_red     <= '0;
      rec_yellow  <= '0;
      rec_blue    <= '0;
      total_notes <= 8'd0;
      beat_idx    <= '0;
      recording   <= 1'b0;
      done        <= 1'b0;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
      prev  <= sync2;
      case (state)
        IDLE, DONE: begin
          pending <= 3'b000;
          if (start) begin
            rec_red     <= '0;
            rec_yellow  <= '0;
            rec_blue    <= '0;
            total_notes <= 8'd0;
            beat_idx    <= '0;
            state       <= RECORD;
            recording   <= 1'b1;
            done        <= 1'b0;
          end
        end
        RECORD: begin
          if (beat_tick) begin
            // slot k lands at bit LANE_LEN-1-k so slot 0 is the MSB
            for (int i = 0; i < LANE_LEN; i++) begin
              if (i == LANE_LEN - 1 - int'(beat_idx)) begin
                rec_red[i]    <= slot[2];
                rec_yellow[i] <= slot[1];
                rec_blue[i]   <= slot[0];
              end
            end
            total_notes <= sum[8] ? 8'hFF : sum[7:0];
            beat_idx    <= beat_idx + IDX_W'(1);
          end
          if (beat_tick || stop) pending <= 3'b000;
          else                   pending <= pending | press;
          if ((beat_tick && last_slot) || stop) begin
            state     <= DONE;
            recording <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          recording <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: default, LANE_LEN=8 and LANE_LEN=512 instances on shared stimulus.
module tb_note_recorder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic beat_tick = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [2:0] keys_n = 3'b111;

  logic [99:0] m_red, m_yel, m_blu;
  logic [7:0]  m_tot;
  logic [6:0]  m_idx;
  logic        m_rec, m_done;

  logic [7:0]  s_red, s_yel, s_blu;
  logic [7:0]  s_tot;
  logic [3:0]  s_idx;
  logic        s_rec, s_done;

  logic [511:0] b_red, b_yel, b_blu;
  logic [7:0]   b_tot;
  logic [8:0]   b_idx;
  logic         b_rec, b_done;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  note_recorder u_main (
    .clk(clk), .resetn(resetn), .beat_tick(beat_tick), .start(start), .stop(stop),
    .keys_n(keys_n), .rec_red(m_red), .rec_yellow(m_yel), .rec_blue(m_blu),
    .total_notes(m_tot), .beat_idx(m_idx), .recording(m_rec), .done(m_done));

  note_recorder #(.LANE_LEN(8), .IDX_W(4)) u_small (
    .clk(clk), .resetn(resetn), .beat_tick(beat_tick), .start(start), .stop(stop),
    .keys_n(keys_n), .rec_red(s_red), .rec_yellow(s_yel), .rec_blue(s_blu),
    .total_notes(s_tot), .beat_idx(s_idx), .recording(s_rec), .done(s_done));

  note_recorder #(.LANE_LEN(512), .IDX_W(9)) u_big (
    .clk(clk), .resetn(resetn), .beat_tick(beat_tick), .start(start), .stop(stop),
    .keys_n(keys_n), .rec_red(b_red), .rec_yellow(b_yel), .rec_blue(b_blu),
    .total_notes(b_tot), .beat_idx(b_idx), .recording(b_rec), .done(b_done));

  typedef struct {
    logic [2:0] keys;
    bit         rel;
    bit         stp;
    bit         commit;
    logic [2:0] slot;
    int         total;
    int         idx;
    bit         rec;
    bit         dn;
  } row_t;

  row_t tbl[7];
  row_t sbq[$];
  row_t e;
  logic [99:0] xr, xy, xb;

`ifdef NOTE_RECORDER_SINGLE_LANE_EN
  localparam int CH = 0;
  localparam logic [2:0] CHORD_SLOT = 3'b010;
`else
  localparam int CH = 1;
  localparam logic [2:0] CHORD_SLOT = 3'b011;
`endif

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // k is active-high; the key is held 3 cycles so the press reaches pending before the beat
  task automatic do_beat(input logic [2:0] k, input bit rel, input bit stp);
    keys_n = ~k;
    repeat (3) @(negedge clk);
    if (rel) keys_n = 3'b111;
    beat_tick = 1'b1;
    stop = stp;
    @(negedge clk);
    beat_tick = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    //          keys  rel stp cmt slot        total   idx rec dn
    tbl[0] = '{3'b100, 1, 0, 1, 3'b100,     1,      1, 1, 0};
    tbl[1] = '{3'b011, 1, 0, 1, CHORD_SLOT, 2 + CH, 2, 1, 0};
    tbl[2] = '{3'b100, 0, 0, 1, 3'b100,     3 + CH, 3, 1, 0};
    tbl[3] = '{3'b100, 0, 0, 1, 3'b000,     3 + CH, 4, 1, 0};
    tbl[4] = '{3'b100, 1, 0, 1, 3'b000,     3 + CH, 5, 1, 0};
    tbl[5] = '{3'b001, 1, 1, 1, 3'b001,     4 + CH, 6, 0, 1};
    tbl[6] = '{3'b100, 1, 0, 0, 3'b000,     4 + CH, 6, 0, 1};
    xr = '0; xy = '0; xb = '0;

    do_reset();
    chk("reset_total", 512'(m_tot), 512'(0));
    chk("reset_idx", 512'(m_idx), 512'(0));
    chk("reset_rec", 512'(m_rec), 512'(0));
    chk("reset_done", 512'(m_done), 512'(0));
    chk("reset_red", 512'(m_red), 512'(0));

    // beat and stop in IDLE are ignored
    do_beat(3'b100, 1, 1);
    chk("idle_ignore_idx", 512'(m_idx), 512'(0));
    chk("idle_ignore_red", 512'(m_red), 512'(0));

    do_start();
    chk("start_rec", 512'(m_rec), 512'(1));

    for (int i = 0; i < 7; i++) begin
      sbq.push_back(tbl[i]);
      do_beat(tbl[i].keys, tbl[i].rel, tbl[i].stp);
      e = sbq.pop_front();
      if (e.commit) begin
        xr[100 - e.idx] = e.slot[2];
        xy[100 - e.idx] = e.slot[1];
        xb[100 - e.idx] = e.slot[0];
      end
      chk($sformatf("row%0d_red", i), 512'(m_red), 512'(xr));
      chk($sformatf("row%0d_yellow", i), 512'(m_yel), 512'(xy));
      chk($sformatf("row%0d_blue", i), 512'(m_blu), 512'(xb));
      chk($sformatf("row%0d_total", i), 512'(m_tot), 512'(e.total));
      chk($sformatf("row%0d_idx", i), 512'(m_idx), 512'(e.idx));
      chk($sformatf("row%0d_rec", i), 512'(m_rec), 512'(e.rec));
      chk($sformatf("row%0d_done", i), 512'(m_done), 512'(e.dn));
    end

    // restart from DONE clears everything
    do_start();
    chk("restart_red", 512'(m_red), 512'(0));
    chk("restart_yellow", 512'(m_yel), 512'(0));
    chk("restart_blue", 512'(m_blu), 512'(0));
    chk("restart_total", 512'(m_tot), 512'(0));
    chk("restart_idx", 512'(m_idx), 512'(0));
    chk("restart_rec", 512'(m_rec), 512'(1));
    chk("restart_done", 512'(m_done), 512'(0));

    // press too late for the first beat, caught by the very next beat as a same-cycle press
    keys_n = 3'b011;
    @(negedge clk);
    beat_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    beat_tick = 1'b0;
    keys_n = 3'b111;
    do_beat(3'b000, 1, 0);
    xr = '0;
    xr[98] = 1'b1;
    chk("latency_red", 512'(m_red), 512'(xr));
    chk("latency_total", 512'(m_tot), 512'(1));
    chk("latency_idx", 512'(m_idx), 512'(3));

    do_beat(3'b000, 1, 0);
    do_beat(3'b000, 1, 0);
    chk("pre_reset_idx", 512'(m_idx), 512'(5));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midreset_red", 512'(m_red), 512'(0));
    chk("midreset_total", 512'(m_tot), 512'(0));
    chk("midreset_idx", 512'(m_idx), 512'(0));
    chk("midreset_rec", 512'(m_rec), 512'(0));
    chk("midreset_done", 512'(m_done), 512'(0));

    // fill a short lane completely, then one extra beat
    do_start();
    for (int i = 0; i < 8; i++) do_beat(3'b001, 1, 0);
    chk("small_blue", 512'(s_blu), 512'(8'hFF));
    chk("small_total", 512'(s_tot), 512'(8));
    chk("small_idx", 512'(s_idx), 512'(8));
    chk("small_done", 512'(s_done), 512'(1));
    do_beat(3'b001, 1, 0);
    chk("small_9th_blue", 512'(s_blu), 512'(8'hFF));
    chk("small_9th_total", 512'(s_tot), 512'(8));
    chk("small_9th_idx", 512'(s_idx), 512'(8));
    chk("small_9th_done", 512'(s_done), 512'(1));

    // saturation of the note total
    do_reset();
    do_start();
    for (int i = 0; i < 300; i++) do_beat(3'b100, 1, 0);
    chk("big_total_sat", 512'(b_tot), 512'(255));
    chk("big_idx", 512'(b_idx), 512'(300));
    chk("big_rec", 512'(b_rec), 512'(1));
    chk("big_red_top", 512'(b_red[511:212]), 512'({300{1'b1}}));
    chk("big_red_rest", 512'(b_red[211:0]), 512'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
